// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds the PC, issues one imem read per PC and holds the fetched word for downstream.
// Latency: FETCH to VALID is one cycle after imem_ack. Best case is one instruction every two cycles.
// Backpressure: VALID holds pc, instr and state until instr_ready. FETCH stalls until imem_ack. Optional check: FETCH_ALIGN_CHECK_EN.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_d;
    logic [31:0] instr_d;

    // The fetch address is always the architectural PC.
    assign imem_addr = pc;

    // Next-state, next-PC and instruction capture, plus the state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc;
        instr_d     = instr;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // pc still holds RESET_PC here, so this checks the reset vector.
                if (ALIGN_CHK && (pc[1:0] != 2'b00)) begin
                    state_d = ERR;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    // The PC comes straight from npc: wrap-around is the next-PC logic's business.
                    pc_d = npc;
                    if (ALIGN_CHK && (npc[1:0] != 2'b00)) begin
                        state_d = ERR;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            ERR: begin
                // Parked until reset: no requests, nothing offered downstream.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and instruction registers. Reset beats any concurrent ack or advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc      <= RESET_PC;
            instr   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            instr   <= instr_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic set_err;
    assign set_err = (state_d == ERR) && (state_q != ERR);

    // Sticky misaligned-fetch flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (set_err) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = 32'h0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    pc_fetch #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // Reference model: the fetch unit described as "have we started", "are we holding a word", "are we dead".
    logic        m_known   = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_instr   = 32'h0;
    logic        m_started = 1'b0;
    logic        m_have    = 1'b0;
    logic        m_err     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_known = 1'b1; m_pc = RPC; m_instr = 32'h0;
            m_started = 1'b0; m_have = 1'b0; m_err = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
            if (CHK && m_pc[1:0] != 2'b00) m_err = 1'b1;
        end else if (m_err) begin
            // nothing moves until reset
        end else if (!m_have) begin
            if (imem_ack) begin m_instr = imem_rdata; m_have = 1'b1; end
        end else if (instr_ready) begin
            m_pc = npc; m_have = 1'b0;
            if (CHK && npc[1:0] != 2'b00) m_err = 1'b1;
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output at the falling edge.
    task automatic cyc(input logic r, input logic [31:0] n, input logic a,
                       input logic [31:0] d, input logic rdy);
        rst = r; npc = n; imem_ack = a; imem_rdata = d; instr_ready = rdy;
        model_step();
        @(negedge clk);
        if (m_known) begin
            check("pc",          pc,          m_pc);
            check("imem_addr",   imem_addr,   m_pc);
            check("imem_req",    {31'b0, imem_req},    {31'b0, m_started && !m_have && !m_err});
            check("instr",       instr,       m_instr);
            check("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            check("addr_err",    {31'b0, addr_err},    {31'b0, m_err});
        end
    endtask

    logic [31:0] w;

    initial begin
        @(negedge clk);
        // Reset for two cycles: IDLE at the reset vector.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'hffff_ffff, 1);
        check("rst_pc", pc, 32'h3000);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        // IDLE ignores ack and ready.
        cyc(0, 32'h5555_5554, 1, 32'h1234_5678, 1);
        check("fetch_req", {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, 32'h3000);
        check("idle_instr", instr, 32'h0);
        // Same-cycle ack then advance.
        cyc(0, 0, 1, 32'h2408_0005, 0);
        check("cap_instr", instr, 32'h2408_0005);
        check("cap_valid", {31'b0, instr_valid}, 32'd1);
        cyc(0, 32'h3004, 0, 0, 1);
        check("adv_pc", pc, 32'h3004);
        check("adv_req", {31'b0, imem_req}, 32'd1);
        // Three wait states, capture on the fourth cycle.
        for (int i = 0; i < 3; i++) begin
            cyc(0, $urandom, 0, $urandom, $urandom_range(0, 1));
            check("ws_addr", imem_addr, 32'h3004);
            check("ws_valid", {31'b0, instr_valid}, 32'd0);
        end
        cyc(0, 0, 1, 32'hcafe_0001, 0);
        check("ws_cap", instr, 32'hcafe_0001);
        // Backpressure: npc churns and ack pulses, nothing moves.
        for (int i = 0; i < 5; i++) begin
            cyc(0, $urandom, i[0], $urandom, 0);
            check("bp_pc", pc, 32'h3004);
            check("bp_instr", instr, 32'hcafe_0001);
        end
        cyc(0, 32'h3010, 0, 0, 1);
        check("to_3010", imem_addr, 32'h3010);
        // Reset on the same edge as an ack: the ack is lost.
        cyc(1, 0, 1, 32'hdead_beef, 0);
        check("rmf_instr", instr, 32'h0);
        check("rmf_pc", pc, 32'h3000);
        check("rmf_req", {31'b0, imem_req}, 32'd0);
        // Misaligned next PC.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0013, 0);
        cyc(0, 32'h3006, 1, 32'h1111_1111, 1);
        if (CHK) begin
            check("mis_err", {31'b0, addr_err}, 32'd1);
            check("mis_req", {31'b0, imem_req}, 32'd0);
        end else begin
            check("mis_addr", imem_addr, 32'h3006);
            check("mis_req", {31'b0, imem_req}, 32'd1);
        end
        for (int i = 0; i < 4; i++) cyc(0, $urandom, 1, $urandom, 1);
        if (CHK) check("mis_sticky", {31'b0, addr_err}, 32'd1);
        // Randomised traffic, checked every cycle against the model.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            if ($urandom_range(0, 15) != 0) w[1:0] = 2'b00;
            cyc($urandom_range(0, 99) == 0, w, $urandom_range(0, 1), $urandom,
                $urandom_range(0, 2) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
